// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// The unit samples START only in IDLE or DONE; DONE pulses one cycle with RESULT valid.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic [2:0]       SELECT;
  logic [WIDTH-1:0] DATA1;
  logic [WIDTH-1:0] DATA2;
  logic             FLUSH;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             DIV0_FLAG;
  logic [1:0]       STATE;

  modport master (
    output START, SELECT, DATA1, DATA2, FLUSH,
    input  BUSY, DONE, RESULT, DIV0_FLAG, STATE
  );

  modport slave (
    input  START, SELECT, DATA1, DATA2, FLUSH,
    output BUSY, DONE, RESULT, DIV0_FLAG, STATE
  );
endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency RV32M multiply/divide unit: WIDTH shift-add or restoring-divide
// iterations on operand magnitudes, then one sign/special-case fix-up cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         CLK,
  input  logic         RESET,
  muldiv_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d, div0_q, div0_d;
  logic [WIDTH-1:0]   a_mag_q, a_mag_d, b_mag_q, b_mag_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               flag_q, flag_d;

  logic               accept, sgn1, sgn2, in_neg1, in_neg2, sgn_diff;
  logic [WIDTH-1:0]   in_mag1, in_mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_step, prod_fix;
  logic [WIDTH+1:0]   rem_shift, rem_diff;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quot_step, quot_fix, rem_fix, fix_result;

  assign accept  = bus.START && !bus.FLUSH && (state_q == S_IDLE || state_q == S_DONE);
  assign sgn1    = bus.SELECT[2] ? !bus.SELECT[0]
                                 : (bus.SELECT[1:0] == 2'b01 || bus.SELECT[1:0] == 2'b10);
  assign sgn2    = bus.SELECT[2] ? !bus.SELECT[0] : (bus.SELECT[1:0] == 2'b01);
  assign in_neg1 = sgn1 && bus.DATA1[WIDTH-1];
  assign in_neg2 = sgn2 && bus.DATA2[WIDTH-1];
  assign in_mag1 = in_neg1 ? -bus.DATA1 : bus.DATA1;
  assign in_mag2 = in_neg2 ? -bus.DATA2 : bus.DATA2;

  // Multiplier sits in the low half of prod_q and is shifted out as the product grows.
  assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
  assign prod_step = {mul_sum, prod_q[WIDTH-1:1]};

  assign rem_shift = {rem_q, quot_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {2'b00, b_mag_q};
  assign rem_step  = rem_diff[WIDTH+1] ? rem_shift[WIDTH:0] : rem_diff[WIDTH:0];
  assign quot_step = {quot_q[WIDTH-2:0], ~rem_diff[WIDTH+1]};

  assign sgn_diff = a_neg_q ^ b_neg_q;
  assign prod_fix = sgn_diff ? -prod_q : prod_q;
  assign quot_fix = sgn_diff ? -quot_q : quot_q;
  assign rem_fix  = a_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  // A zero divisor leaves the dividend in the remainder, so REM/REMU already return DATA1;
  // most-negative / -1 yields most-negative quotient and zero remainder without extra logic.
  always_comb begin
    fix_result = rem_fix;
    case (sel_q)
      3'b000:                 fix_result = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result = div0_q ? '1 : quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    div0_d   = div0_q;
    a_mag_d  = a_mag_q;
    b_mag_d  = b_mag_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    flag_d   = flag_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d = S_CALC;
          sel_d   = bus.SELECT;
          a_neg_d = in_neg1;
          b_neg_d = in_neg2;
          a_mag_d = in_mag1;
          b_mag_d = in_mag2;
          div0_d  = (bus.DATA2 == '0);
          cnt_d   = '0;
          prod_d  = {{WIDTH{1'b0}}, in_mag2};
          rem_d   = '0;
          quot_d  = in_mag1;
        end
      end
      S_CALC: begin
        if (bus.FLUSH) begin
          state_d = S_IDLE;
        end else begin
          prod_d = prod_step;
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (bus.FLUSH) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_result;
          flag_d   = sel_q[2] && div0_q;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      a_mag_q  <= '0;
      b_mag_q  <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      div0_q   <= div0_d;
      a_mag_q  <= a_mag_d;
      b_mag_q  <= b_mag_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      flag_q   <= flag_d;
    end
  end

  assign bus.BUSY      = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.DONE      = (state_q == S_DONE);
  assign bus.RESULT    = result_q;
  assign bus.DIV0_FLAG = flag_q;
  assign bus.STATE     = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: driver tasks push expected results from a plain-arithmetic
// RV32M model; a negedge monitor pops and compares on every DONE pulse.
module tb_muldiv_unit;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_f_q[$];
  int           exp_c_q[$];
  logic [W-1:0] last_res = '0;
  logic         last_flag = 1'b0;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event (cycle %0d)", name, cyc);
  endtask

  // Reference: RV32M semantics via 64-bit arithmetic; SV truncates division toward zero.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic f);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    f  = op[2] && (b == '0);
    p  = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: begin p = sa / ((b == '0) ? 64'sd1 : sb); r = (b == '0) ? '1 : p[31:0]; end
      3'd5: r = (b == '0) ? '1 : a / b;
      3'd6: begin p = sa % ((b == '0) ? 64'sd1 : sb); r = (b == '0) ? a : p[31:0]; end
      default: r = (b == '0) ? a : a % b;
    endcase
  endfunction

  // Called just after a negedge; returns at the negedge after the accepting posedge.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    logic [W-1:0] r;
    logic f;
    guard = 0;
    while (bus.BUSY === 1'b1 && guard < 200) begin
      @(negedge CLK);
      guard++;
    end
    if (guard >= 200) fail("issue_wait_busy");
    bus.SELECT = op;
    bus.DATA1  = a;
    bus.DATA2  = b;
    bus.START  = 1'b1;
    model(op, a, b, r, f);
    exp_q.push_back(r);
    exp_f_q.push_back(f);
    exp_c_q.push_back(cyc + 1);
    @(negedge CLK);
    bus.START = 1'b0;
    bus.DATA1 = $urandom;
    bus.DATA2 = $urandom;
  endtask

  task automatic wait_done(output int busy_n);
    int guard;
    busy_n = 0;
    guard  = 0;
    while (bus.DONE !== 1'b1 && guard < 200) begin
      if (bus.BUSY === 1'b1) busy_n++;
      @(negedge CLK);
      guard++;
    end
    if (guard >= 200) fail("wait_done_timeout");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor / scoreboard
  initial begin
    logic prev_done;
    logic [W-1:0] er;
    logic ef;
    int ec;
    prev_done = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET === 1'b1 && bus.DONE === 1'b1) begin
        check("done_single_pulse", 64'(prev_done), 64'd0);
        check("busy_low_in_done", 64'(bus.BUSY), 64'd0);
        if (exp_q.size() == 0) begin
          fail("unexpected_done");
        end else begin
          er = exp_q.pop_front();
          ef = exp_f_q.pop_front();
          ec = exp_c_q.pop_front();
          check("result", 64'(bus.RESULT), 64'(er));
          check("div0_flag", 64'(bus.DIV0_FLAG), 64'(ef));
          check("latency_edges", 64'(cyc - ec), 64'(W + 1));
          last_res  = er;
          last_flag = ef;
        end
      end
      prev_done = (RESET === 1'b1) ? bus.DONE : 1'b0;
    end
  end

  logic [2:0]   d_op [15] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4,
                               3'd4, 3'd6, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [W-1:0] d_a  [15] = '{32'd20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'd5, 32'h8000_0000,
                              32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h1234_5678};
  logic [W-1:0] d_b  [15] = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd3,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int bn;
    int guard;
    bit pending;
    RESET      = 1'b0;
    bus.START  = 1'b0;
    bus.FLUSH  = 1'b0;
    bus.SELECT = '0;
    bus.DATA1  = '0;
    bus.DATA2  = '0;
    repeat (2) @(negedge CLK);
    check("reset_busy", 64'(bus.BUSY), 64'd0);
    check("reset_done", 64'(bus.DONE), 64'd0);
    check("reset_result", 64'(bus.RESULT), 64'd0);
    check("reset_div0", 64'(bus.DIV0_FLAG), 64'd0);
    RESET = 1'b1;
    @(negedge CLK);

    // MUL 20*10 with BUSY length, then the directed corner table back-to-back
    issue(3'd0, 32'd20, 32'd10);
    check("busy_after_accept", 64'(bus.BUSY), 64'd1);
    wait_done(bn);
    check("busy_cycles", 64'(bn), 64'(W + 1));
    for (int i = 1; i < 15; i++) issue(d_op[i], d_a[i], d_b[i]);
    wait_done(bn);
    @(negedge CLK);

    // START held while BUSY is ignored; drop it in the DONE cycle
    issue(3'd5, 32'd100, 32'd7);
    bus.START = 1'b1;
    guard = 0;
    while (guard < 200) begin
      bus.DATA1 = $urandom;
      bus.DATA2 = $urandom;
      @(negedge CLK);
      guard++;
      if (bus.DONE === 1'b1) break;
    end
    bus.START = 1'b0;
    if (guard >= 200) fail("start_held_timeout");
    repeat (3) @(negedge CLK);
    check("start_held_not_queued", 64'(bus.BUSY), 64'd0);

    // FLUSH in CALC cycle 10: no DONE, RESULT and DIV0_FLAG kept
    issue(3'd0, 32'd9, 32'd9);
    repeat (9) @(negedge CLK);
    bus.FLUSH = 1'b1;
    @(negedge CLK);
    bus.FLUSH = 1'b0;
    void'(exp_q.pop_back());
    void'(exp_f_q.pop_back());
    void'(exp_c_q.pop_back());
    check("flush_calc_busy", 64'(bus.BUSY), 64'd0);
    check("flush_calc_result_kept", 64'(bus.RESULT), 64'(last_res));
    check("flush_calc_flag_kept", 64'(bus.DIV0_FLAG), 64'(last_flag));
    repeat (W + 4) @(negedge CLK);

    // FLUSH and START together in IDLE: nothing accepted
    bus.START = 1'b1;
    bus.FLUSH = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    check("flush_start_idle", 64'(bus.BUSY), 64'd0);

    // FLUSH with START in the DONE cycle: pulse shown, nothing accepted
    issue(3'd7, 32'd7, 32'd0);
    wait_done(bn);
    bus.START = 1'b1;
    bus.FLUSH = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.FLUSH = 1'b0;
    check("flush_in_done_no_accept", 64'(bus.BUSY), 64'd0);
    repeat (W + 4) @(negedge CLK);

    // Asynchronous reset mid-CALC, then a fresh MUL 3*4
    issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
    repeat (5) @(negedge CLK);
    #2 RESET = 1'b0;
    #1;
    check("async_reset_busy", 64'(bus.BUSY), 64'd0);
    check("async_reset_done", 64'(bus.DONE), 64'd0);
    check("async_reset_result", 64'(bus.RESULT), 64'd0);
    check("async_reset_div0", 64'(bus.DIV0_FLAG), 64'd0);
    exp_q.delete();
    exp_f_q.delete();
    exp_c_q.delete();
    last_res  = '0;
    last_flag = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    issue(3'd0, 32'd3, 32'd4);
    pending = 1'b1;

    // Random operations, mostly back-to-back, sometimes with idle gaps
    for (int i = 0; i < 60; i++) begin
      if (pending && $urandom_range(0, 3) == 0) begin
        wait_done(bn);
        pending = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge CLK);
      end
      issue(3'($urandom_range(0, 7)), pick(), pick());
      pending = 1'b1;
    end
    if (pending) wait_done(bn);
    repeat (W + 5) @(negedge CLK);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle multiply/divide unit that implements all eight RV32M operations at a fixed, deterministic latency.
- Sits beside the single-cycle ALU in the EX stage. The pipeline stalls on BUSY, captures RESULT on DONE, and can cancel an in-flight operation with FLUSH.
- Uses radix-2 shift-add multiplication and restoring division on operand magnitudes, followed by a sign/special-case fix-up cycle.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 8..64, even.
- CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; do not override).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only when the unit can accept.
- SELECT  input  3  operation, funct3 order: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- DATA1  input  WIDTH  rs1 operand (multiplicand / dividend).
- DATA2  input  WIDTH  rs2 operand (multiplier / divisor).
- FLUSH  input  1  synchronous cancel of the current operation.
- BUSY  output  1  high while an accepted operation is in CALC or FIX.
- DONE  output  1  single-cycle pulse; RESULT is valid in that cycle.
- RESULT  output  WIDTH  registered result, held until the next accept.
- DIV0_FLAG  output  1  qualified by DONE; set when a DIV/DIVU/REM/REMU divisor was 0.

Behaviour:
- Reset (RESET=0, asynchronous): state goes to IDLE. BUSY, DONE, RESULT and DIV0_FLAG are all 0. Internal registers are cleared. This holds mid-operation too: any in-flight work is discarded and no DONE is produced.
- States: IDLE, CALC, FIX, DONE.
  - IDLE and DONE both accept a request.
  - Accept condition: START=1, FLUSH=0 at the clock edge.
- On accept:
  - Latch SELECT, the signs and the magnitudes of the operands.
    - Signed-operand rule: DATA1 is signed for MULH, MULHSU, DIV, REM; DATA2 is signed for MULH, DIV, REM.
  - Clear the counter and go to CALC.
- CALC: one iteration per cycle for exactly WIDTH cycles, then go to FIX.
  - Multiply keeps a 2*WIDTH-bit product register.
  - Divide keeps a WIDTH+1-bit partial remainder and a WIDTH-bit quotient.
- FIX (1 cycle):
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Select the result: low half for MUL, high half for the MULH* variants.
  - Special cases, which override the computed value:
    - Divisor 0: DIV/DIVU give all ones; REM/REMU give DATA1 unchanged; DIV0_FLAG=1.
    - DIV with most-negative / -1: result is most-negative.
    - REM with most-negative / -1: result is 0.
  - Register RESULT, then go to DONE.
- DONE: DONE=1 and BUSY=0 for one cycle.
  - START in this cycle is accepted (back-to-back), giving the next state CALC.
  - Otherwise the next state is IDLE.
  - DONE never asserts for two consecutive cycles.
- Latency: accept at edge N gives DONE=1 in the cycle following edge N+WIDTH+1, i.e. WIDTH+2 cycles from the accept edge. The latency is identical for all SELECT values and all operands, including the special cases.
- BUSY timing: BUSY=1 from the cycle after accept through the FIX cycle; 0 in IDLE and DONE. START while BUSY=1 is ignored; no queuing.
- FLUSH:
  - In CALC or FIX: go to IDLE at the next edge, with no DONE and RESULT unchanged.
  - In DONE: DONE still shows its pulse, then go to IDLE.
  - FLUSH and START at the same edge: FLUSH wins and nothing is accepted.
- Operand changes after accept have no effect.
- DIV0_FLAG is updated in FIX alongside RESULT and holds until the next FIX.

Test Plan:
- WIDTH=32. MUL 20*10: RESULT=200 exactly 34 cycles after the accept edge; DONE is a 1-cycle pulse; BUSY=1 for 33 cycles.
- Products: MULH 0xFFFFFFFF*0xFFFFFFFF gives 0x00000000; MULHU of the same operands gives 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 gives 0xFFFFFFFF.
- Divide: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 0x80000000/3 gives 0x2AAAAAAA; REMU 7/0 gives 7 with DIV0_FLAG=1; DIV 5/0 gives 0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0 with DIV0_FLAG=0; latency still 34 cycles.
- Control: START held during BUSY is ignored. START in the DONE cycle is accepted, and the second DONE arrives 34 cycles later. FLUSH in CALC cycle 10 gives IDLE with no DONE and the previous RESULT kept.
- Reset: drive RESET low asynchronously mid-CALC, between edges. All outputs go to 0 immediately. After release, a fresh MUL 3*4 gives 12 at the nominal latency.
